// File: rtl/fifo_serial_reader_pkg.sv
// Shared definitions for the FIFO-draining serial transmitter: state encodings,
// frame-length arithmetic and counter sizing.
package fifo_serial_reader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_POP    = 3'd1,
    ST_LOAD   = 3'd2,
    ST_START  = 3'd3,
    ST_DATA   = 3'd4,
    ST_PARITY = 3'd5,
    ST_STOP   = 3'd6
  } state_t;

  // Cycles from the first START cycle through the last STOP cycle.
  function automatic int frame_cycles(input int width, input int bit_cycles,
                                      input int parity_en);
    return (2 + width + parity_en) * bit_cycles;
  endfunction

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_serial_reader_bit_timer.sv
// Bit-period timer: counts 0..BIT_CYCLES-1 and flags the last cycle of each bit.
module bit_timer
  import fifo_serial_reader_pkg::*;
#(
  parameter int BIT_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int CNT_W = cnt_width(BIT_CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BIT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || restart || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/fifo_serial_reader.sv
// Pops words from a FIFO and sends each as a serial frame:
// start bit, data LSB first, optional even parity, stop bit.
module fifo_serial_reader
  import fifo_serial_reader_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int BIT_CYCLES = 4,
  parameter int PARITY_EN  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tx_en,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             pop,
  output logic             tx_line,
  output logic             busy,
  output logic             frame_done
);

  localparam int IDX_W = cnt_width(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  function automatic logic even_parity(input logic [WIDTH-1:0] d);
    return ^d;
  endfunction

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] bit_idx;
  logic [WIDTH-1:0] shreg;
  logic             par_bit;
  logic             restart;
  logic             tick;

  // The timer is held at zero until the frame proper begins in START.
  assign restart = (state == ST_IDLE) || (state == ST_POP) || (state == ST_LOAD);

  bit_timer #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_bit_timer (
    .clk    (clk),
    .reset  (reset),
    .restart(restart),
    .tick   (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || (state != ST_DATA)) begin
      bit_idx <= '0;
    end else if (tick) begin
      bit_idx <= (bit_idx == LAST_IDX) ? '0 : bit_idx + 1'b1;
    end
  end

  // Datapath: capture in LOAD only, so fifo_data is ignored in every other cycle.
  always_ff @(posedge clk) begin
    if (state == ST_LOAD) begin
      shreg   <= fifo_data;
      par_bit <= even_parity(fifo_data);
    end else if ((state == ST_DATA) && tick) begin
      shreg <= shreg >> 1;
    end
  end

  always_comb begin
    state_nxt  = state;
    pop        = 1'b0;
    tx_line    = 1'b1;
    busy       = (state != ST_IDLE);
    frame_done = 1'b0;
    case (state)
      ST_IDLE: begin
        if (tx_en && !fifo_empty) begin
          state_nxt = ST_POP;
        end
      end
      ST_POP: begin
        pop       = 1'b1;
        state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        state_nxt = ST_START;
      end
      ST_START: begin
        tx_line = 1'b0;
        if (tick) begin
          state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        tx_line = shreg[0];
        if (tick && (bit_idx == LAST_IDX)) begin
          state_nxt = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        tx_line = par_bit;
        if (tick) begin
          state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        if (tick) begin
          frame_done = 1'b1;
          state_nxt  = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fifo_serial_reader.sv
// Bench for fifo_serial_reader: three configurations, each fed by a small FIFO
// model, with a line decoder feeding a scoreboard of expected frames.
module tb_fifo_serial_reader;

  typedef struct {
    int         inst;
    logic [3:0] data;
    logic       par;
    int         len;
  } exp_t;

  typedef struct {
    int         inst;
    logic [3:0] data;
    logic       par;
    int         len;
    bit         shape_ok;
    longint     start;
  } frame_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       fifo_rst;
  logic [2:0] tx_en;
  logic [2:0] push;
  logic [2:0] tx_line_w;
  logic [2:0] pop_w;
  logic [2:0] busy_w;
  logic [2:0] fd_w;
  logic [2:0] fempty;
  logic [3:0] push_data [3];
  logic [3:0] fdout     [3];

  always #5 clk = ~clk;

  // Instance 0: defaults. Instance 1: no parity. Instance 2: one cycle per bit.
  fifo_serial_reader #(.WIDTH(4), .BIT_CYCLES(4), .PARITY_EN(1)) dut_a (
    .clk(clk), .reset(reset), .tx_en(tx_en[0]), .fifo_empty(fempty[0]),
    .fifo_data(fdout[0]), .pop(pop_w[0]), .tx_line(tx_line_w[0]),
    .busy(busy_w[0]), .frame_done(fd_w[0]));

  fifo_serial_reader #(.WIDTH(4), .BIT_CYCLES(4), .PARITY_EN(0)) dut_b (
    .clk(clk), .reset(reset), .tx_en(tx_en[1]), .fifo_empty(fempty[1]),
    .fifo_data(fdout[1]), .pop(pop_w[1]), .tx_line(tx_line_w[1]),
    .busy(busy_w[1]), .frame_done(fd_w[1]));

  fifo_serial_reader #(.WIDTH(4), .BIT_CYCLES(1), .PARITY_EN(1)) dut_c (
    .clk(clk), .reset(reset), .tx_en(tx_en[2]), .fifo_empty(fempty[2]),
    .fifo_data(fdout[2]), .pop(pop_w[2]), .tx_line(tx_line_w[2]),
    .busy(busy_w[2]), .frame_done(fd_w[2]));

  // 4-deep FIFO models; the empty flag trails the count by one edge, so it
  // settles two edges after a push or pop.
  logic [3:0] fmem [3][4];
  int         fcnt [3];
  logic [1:0] rdp  [3];
  logic [1:0] wrp  [3];
  int         underflow [3];

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (fifo_rst) begin
        fcnt[k]      <= 0;
        rdp[k]       <= 2'd0;
        wrp[k]       <= 2'd0;
        fempty[k]    <= 1'b1;
        underflow[k] <= 0;
        fdout[k]     <= 4'd0;
      end else begin
        if (pop_w[k]) begin
          if (fcnt[k] == 0 || fempty[k]) begin
            underflow[k] <= underflow[k] + 1;
          end else begin
            fdout[k] <= fmem[k][rdp[k]];
            rdp[k]   <= rdp[k] + 2'd1;
          end
        end
        if (push[k]) begin
          fmem[k][wrp[k]] <= push_data[k];
          wrp[k]          <= wrp[k] + 2'd1;
        end
        fcnt[k]   <= fcnt[k] + (push[k] ? 1 : 0) - ((pop_w[k] && fcnt[k] > 0) ? 1 : 0);
        fempty[k] <= (fcnt[k] == 0);
      end
    end
  end

  longint cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Line decoder: collects tx_line from the falling start edge up to frame_done.
  frame_t      got_q [$];
  exp_t        exp_q [$];
  bit          mon_act   [3] = '{0, 0, 0};
  int          mon_len   [3];
  logic [63:0] mon_bits  [3];
  longint      mon_start [3];
  int          fd_total  [3] = '{0, 0, 0};
  int          pop_total [3] = '{0, 0, 0};

  always @(negedge clk) begin : mon
    int     bc;
    int     np;
    frame_t f;
    for (int k = 0; k < 3; k++) begin
      if (fd_w[k])  fd_total[k]++;
      if (pop_w[k]) pop_total[k]++;
      if (reset) begin
        mon_act[k] = 0;
      end else if (!mon_act[k]) begin
        if (!tx_line_w[k]) begin
          mon_act[k]   = 1;
          mon_len[k]   = 1;
          mon_bits[k]  = '1;
          mon_bits[k][0] = 1'b0;
          mon_start[k] = cyc_cnt;
        end
      end else begin
        mon_bits[k][mon_len[k]] = tx_line_w[k];
        mon_len[k]++;
        if (fd_w[k] || mon_len[k] >= 60) begin
          bc = (k == 2) ? 1 : 4;
          np = mon_len[k] / bc;
          f.inst     = k;
          f.len      = mon_len[k];
          f.start    = mon_start[k];
          f.shape_ok = (mon_len[k] % bc == 0) && (np >= 6) && (np <= 7);
          for (int p = 0; p < np; p++)
            for (int j = 0; j < bc; j++)
              if (mon_bits[k][p*bc+j] !== mon_bits[k][p*bc]) f.shape_ok = 0;
          if (mon_bits[k][0] !== 1'b0) f.shape_ok = 0;
          if (np >= 1 && mon_bits[k][(np-1)*bc] !== 1'b1) f.shape_ok = 0;
          for (int i = 0; i < 4; i++) f.data[i] = mon_bits[k][(1+i)*bc];
          f.par = (np == 7) ? mon_bits[k][5*bc] : 1'b0;
          got_q.push_back(f);
          mon_act[k] = 0;
        end
      end
    end
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_word(input int k, input logic [3:0] d, input logic par, input int len);
    exp_t e;
    push[k]      = 1'b1;
    push_data[k] = d;
    e.inst = k; e.data = d; e.par = par; e.len = len;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    push[k] = 1'b0;
  endtask

  task automatic get_frame(output frame_t f);
    int   n;
    exp_t e;
    n = 0;
    f = '{default: 0};
    while (got_q.size() == 0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("frame_arrived", longint'(got_q.size() != 0), 1);
    if (got_q.size() != 0) begin
      f = got_q.pop_front();
      check("exp_pending", longint'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("frame_inst", f.inst, e.inst);
        check("frame_data", f.data, e.data);
        check("frame_parity", f.par, e.par);
        check("frame_len", f.len, e.len);
      end
      check("frame_shape", f.shape_ok, 1);
    end
  endtask

  exp_t       vecs [6];
  frame_t     f;
  frame_t     prev;
  int         p0;
  int         fd0;
  int         n;
  logic [3:0] d;
  exp_t       dropped;

  initial begin
    vecs[0] = '{inst: 0, data: 4'b1010, par: 1'b0, len: 28};
    vecs[1] = '{inst: 0, data: 4'b0111, par: 1'b1, len: 28};
    vecs[2] = '{inst: 0, data: 4'b0000, par: 1'b0, len: 28};
    vecs[3] = '{inst: 0, data: 4'b1101, par: 1'b1, len: 28};
    vecs[4] = '{inst: 1, data: 4'b0111, par: 1'b0, len: 24};
    vecs[5] = '{inst: 1, data: 4'b1001, par: 1'b0, len: 24};

    reset    = 1'b1;
    fifo_rst = 1'b1;
    tx_en    = 3'b000;
    push     = 3'b000;
    for (int k = 0; k < 3; k++) push_data[k] = 4'd0;
    tick(3);
    check("reset_tx_line", tx_line_w, 3'b111);
    check("reset_pop", pop_w, 3'b000);
    check("reset_busy", busy_w, 3'b000);
    check("reset_frame_done", fd_w, 3'b000);
    reset    = 1'b0;
    fifo_rst = 1'b0;
    tick(2);

    for (int i = 0; i < 6; i++) begin
      p0  = pop_total[vecs[i].inst];
      fd0 = fd_total[vecs[i].inst];
      push_word(vecs[i].inst, vecs[i].data, vecs[i].par, vecs[i].len);
      tx_en[vecs[i].inst] = 1'b1;
      get_frame(f);
      tick(2);
      check("pop_once", pop_total[vecs[i].inst] - p0, 1);
      check("frame_done_once", fd_total[vecs[i].inst] - fd0, 1);
      tx_en[vecs[i].inst] = 1'b0;
    end

    // Back-to-back drain of three words.
    p0 = pop_total[0];
    for (int i = 1; i <= 3; i++) begin
      d = 4'(i);
      push_word(0, d, ^d, 28);
    end
    tick(3);
    tx_en[0] = 1'b1;
    prev = '{default: 0};
    for (int j = 0; j < 3; j++) begin
      get_frame(f);
      if (j > 0) check("b2b_gap", f.start - (prev.start + prev.len), 3);
      prev = f;
    end
    tick(4);
    check("b2b_pops", pop_total[0] - p0, 3);
    check("b2b_underflow", underflow[0], 0);
    check("b2b_empty", fempty[0], 1);
    tx_en[0] = 1'b0;

    // tx_en gating and launch latency.
    p0 = pop_total[0];
    push_word(0, 4'h5, 1'b0, 28);
    tick(10);
    check("gated_no_pop", pop_total[0] - p0, 0);
    check("gated_tx_line", tx_line_w[0], 1);
    check("gated_no_frame", mon_act[0], 0);
    tx_en[0] = 1'b1;
    tick(1);
    check("launch_pop_lat1", pop_w[0], 1);
    tick(1);
    check("launch_pop_single", pop_w[0], 0);
    check("launch_load_high", tx_line_w[0], 1);
    tick(1);
    check("launch_start_lat3", tx_line_w[0], 0);
    tick(6);
    push_word(0, 4'h6, 1'b0, 28);
    tx_en[0] = 1'b0;
    get_frame(f);
    tick(40);
    check("tx_en_drop_no_pop", pop_total[0] - p0, 1);
    check("tx_en_drop_no_frame", got_q.size(), 0);
    tx_en[0] = 1'b1;
    get_frame(f);

    // Reset in the middle of data bit 2.
    p0  = pop_total[0];
    push_word(0, 4'hC, 1'b0, 28);
    n = 0;
    while (tx_line_w[0] !== 1'b0 && n < 50) begin
      tick(1);
      n++;
    end
    check("rst_start_seen", tx_line_w[0], 0);
    tick(13);
    check("rst_bit2_value", tx_line_w[0], 1);
    fd0   = fd_total[0];
    reset = 1'b1;
    tick(1);
    check("rst_tx_line", tx_line_w[0], 1);
    check("rst_busy", busy_w[0], 0);
    check("rst_pop", pop_w[0], 0);
    check("rst_frame_done", fd_w[0], 0);
    reset = 1'b0;
    if (exp_q.size() != 0) dropped = exp_q.pop_front();
    tick(10);
    check("rst_no_frame_done", fd_total[0] - fd0, 0);
    check("rst_no_frame", got_q.size(), 0);
    check("rst_single_pop", pop_total[0] - p0, 1);
    push_word(0, 4'h3, 1'b0, 28);
    get_frame(f);
    tx_en[0] = 1'b0;

    // One cycle per bit: fill, then drain four words.
    p0 = pop_total[2];
    for (int i = 0; i < 4; i++) begin
      d = 4'($urandom_range(0, 15));
      push_word(2, d, ^d, 7);
    end
    tick(3);
    tx_en[2] = 1'b1;
    prev = '{default: 0};
    for (int j = 0; j < 4; j++) begin
      get_frame(f);
      if (j > 0) check("fast_gap", f.start - (prev.start + prev.len), 3);
      prev = f;
    end
    tick(6);
    check("fast_pops", pop_total[2] - p0, 4);
    check("fast_underflow", underflow[2], 0);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
